axis_pixel_tx: RTL

Output-side AXI4-Stream master for the 3x3 image filter IP. Accepts one filtered 8-bit pixel per cycle from the accumulator stage, which has no backpressure. Buffers the pixels in an internal FIFO and transmits them downstream with full tvalid/tready handshaking, per-row tlast and start-of-frame tuser. Exports row_space so the line-buffer controller starts a new row only when a full row of output fits.

---
 rtl/filter_pkg.sv | 25 ++
 rtl/pixel_fifo.sv | 56 +++++
 rtl/axis_pixel_tx.sv | 104 ++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// Shared constants and helpers for the 3x3 image filter IP.
// Holds pixel width, default frame geometry and the output-stage state type.
package filter_pkg;

  localparam int PIX_W            = 8;
  localparam int DEF_IMAGE_WIDTH  = 512;
  localparam int DEF_IMAGE_HEIGHT = 510;
  localparam int DEF_FIFO_DEPTH   = 1024;

  // Number of bits needed to index n distinct values (minimum 1).
  function automatic int width_of(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < n) w = i + 1;
    end
    return w;
  endfunction

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock pixel FIFO on an inferred block RAM with registered read.
// The read port prefetches the next head so dout is valid whenever empty is low.
module pixel_fifo
  import filter_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW-1:0]    rd_addr_next;
  logic [AW:0]      count_reg;
  logic [PIX_W-1:0] dout_reg;

  assign rd_addr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

  // Writing the slot about to be read means the FIFO holds just this word next cycle.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= din;
    if (push && (wr_ptr_reg == rd_addr_next)) dout_reg <= din;
    else                                      dout_reg <= mem[rd_addr_next];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_addr_next;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = dout_reg;
  assign count = count_reg;
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/axis_pixel_tx.sv
// AXI4-Stream output stage: FIFO plus one-entry output register with row/frame tags.
// Accepts one pixel per cycle without backpressure; drops and flags when storage is full.
module axis_pixel_tx
  import filter_pkg::*;
#(
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IW_BIT_NUM   = 9,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int IH_BIT_NUM   = 9,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int FIFO_AW      = width_of(DEF_FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             pixel_in_valid,
  output logic             row_space,
  output logic [PIX_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             m_axis_tuser,
  output logic             overflow,
  output logic             frame_done
);

  localparam logic [IW_BIT_NUM-1:0] COL_LAST = IW_BIT_NUM'(IMAGE_WIDTH - 1);
  localparam logic [IH_BIT_NUM-1:0] ROW_LAST = IH_BIT_NUM'(IMAGE_HEIGHT - 1);

  tx_state_t        state_reg, state_next;
  logic [PIX_W-1:0] data_reg, data_next;
  logic [IW_BIT_NUM-1:0] col_reg;
  logic [IH_BIT_NUM-1:0] row_reg;
  logic             overflow_reg, frame_done_reg;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PIX_W-1:0] fifo_dout;
  logic [FIFO_AW:0] fifo_count;
  logic             hs, load, avail, bypass, drop;

  pixel_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (pixel_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    hs         = (state_reg == HOLD) && m_axis_tready;
    load       = (state_reg == EMPTY) || hs;
    avail      = !fifo_empty || pixel_in_valid;
    fifo_pop   = load && !fifo_empty;
    // With an empty FIFO the incoming pixel goes straight to the output register.
    bypass     = load && fifo_empty && pixel_in_valid;
    fifo_push  = pixel_in_valid && !bypass && (!fifo_full || fifo_pop);
    drop       = pixel_in_valid && fifo_full && !fifo_pop;
    state_next = state_reg;
    data_next  = data_reg;
    if (load && avail) data_next = fifo_empty ? pixel_in : fifo_dout;
    case (state_reg)
      EMPTY:   if (avail) state_next = HOLD;
      HOLD:    if (hs && !avail) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= EMPTY;
      data_reg       <= '0;
      col_reg        <= '0;
      row_reg        <= '0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      data_reg       <= data_next;
      frame_done_reg <= hs && (col_reg == COL_LAST) && (row_reg == ROW_LAST);
      if (drop) overflow_reg <= 1'b1;
      if (hs) begin
        if (col_reg == COL_LAST) begin
          col_reg <= '0;
          row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
    end
  end

  assign m_axis_tvalid = (state_reg == HOLD);
  assign m_axis_tdata  = data_reg;
  assign m_axis_tlast  = (col_reg == COL_LAST);
  assign m_axis_tuser  = (col_reg == '0) && (row_reg == '0);
  assign overflow      = overflow_reg;
  assign frame_done    = frame_done_reg;
  assign row_space     = (FIFO_DEPTH - int'(fifo_count)) >= IMAGE_WIDTH;

endmodule
